// File: rtl/piso_arb_ctrl.sv
// piso_arb_ctrl: round-robin two-requester arbiter feeding an MSB-first serializer with an idle gap
module piso_arb_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             grant_id,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       gcnt_q;
  logic             last_q, grant_q, serial_q, frame_q, done_q;
  logic             win0, win1, accept;
  logic [WIDTH-1:0] data_d;
  // Round-robin winner; a ready only opens in IDLE while out of reset
  always_comb begin
    win0       = req0_valid & (~req1_valid | last_q);
    win1       = req1_valid & (~req0_valid | ~last_q);
    req0_ready = reset & (state_q == IDLE) & win0;
    req1_ready = reset & (state_q == IDLE) & win1;
    accept     = req0_ready | req1_ready;
    data_d     = req1_ready ? req1_data : req0_data;
  end
  // Control FSM; the MSB goes straight to serial_out on accept, the rest is shifted out after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          state_q  <= SHIFT;
          sreg_q   <= {data_d[WIDTH-2:0], 1'b0};
          serial_q <= data_d[WIDTH-1];
          frame_q  <= 1'b1;
          cnt_q    <= CNT_LOAD;
          grant_q  <= req1_ready;
          last_q   <= req1_ready;
        end
        SHIFT: if (cnt_q != '0) begin
          serial_q <= sreg_q[WIDTH-1];
          sreg_q   <= {sreg_q[WIDTH-2:0], 1'b0};
          cnt_q    <= cnt_q - 1'b1;
        end else begin
          serial_q <= 1'b0;
          frame_q  <= 1'b0;
          done_q   <= 1'b1;
          gcnt_q   <= GAP_LOAD;
          state_q  <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
        GAP: if (gcnt_q == '0) state_q <= IDLE;
             else gcnt_q <= gcnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign serial_out = serial_q;
  assign frame_out  = frame_q;
  assign grant_id   = grant_q;
  assign done       = done_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_piso_arb_ctrl.sv
// tb_piso_arb_ctrl: scoreboard bench for the arbiter/serializer, plus a zero-gap instance
module tb_piso_arb_ctrl;
  logic clk, reset;
  logic r0v, r1v, r0_ready, r1_ready;
  logic [3:0] r0d, r1d;
  logic serial_out, frame_out, grant_id, busy, done;
  logic gv, g_ready, g_r1_ready, g_serial, g_frame, g_grant, g_busy, g_done;
  logic [3:0] gd;
  int n_chk = 0, n_err = 0;
  int cyc = 0, last_acc = 0, acc_cnt = 0, g_acc = 0, g_low = 0;
  bit g_seen = 0;
  logic prev_frame = 0;
  logic exp_bits[$];
  logic exp_gid[$];
  logic g_bits[$];
  int gaps[$];

  piso_arb_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0_ready),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1_ready),
    .serial_out(serial_out), .frame_out(frame_out), .grant_id(grant_id),
    .busy(busy), .done(done)
  );

  piso_arb_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) dut_g (
    .clk(clk), .reset(reset),
    .req0_valid(gv), .req0_data(gd), .req0_ready(g_ready),
    .req1_valid(1'b0), .req1_data(4'd0), .req1_ready(g_r1_ready),
    .serial_out(g_serial), .frame_out(g_frame), .grant_id(g_grant),
    .busy(g_busy), .done(g_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] d, input logic g);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(d[i]);
    exp_gid.push_back(g);
  endtask

  task automatic wait_acc(input int n);
    int tgt;
    int k;
    tgt = acc_cnt + n;
    k = 0;
    while (acc_cnt < tgt && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_timeout", acc_cnt, tgt);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || exp_bits.size() > 0 || exp_gid.size() > 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_bits", exp_bits.size(), 0);
    chk("drain_gid", exp_gid.size(), 0);
  endtask

  task automatic chk_gaps(input string tag, input int n, input int exp);
    chk({tag, "_count"}, gaps.size(), n);
    for (int i = 1; i < gaps.size(); i++) chk(tag, gaps[i], exp);
  endtask

  // Output monitor: scoreboard pops, done timing, accept spacing
  always @(negedge clk) begin
    cyc++;
    if (frame_out) begin
      if (exp_bits.size() == 0) chk("extra_bit", frame_out, 0);
      else chk("serial_bit", serial_out, exp_bits.pop_front());
    end else chk("serial_idle", serial_out, 0);
    if (done) begin
      chk("done_after_last_bit", prev_frame, 1);
      if (exp_gid.size() == 0) chk("extra_done", done, 0);
      else chk("done_grant_id", grant_id, exp_gid.pop_front());
    end
    chk("ready_onehot", r0_ready & r1_ready, 0);
    if ((r0v && r0_ready) || (r1v && r1_ready)) begin
      gaps.push_back(cyc - last_acc);
      last_acc = cyc;
      acc_cnt++;
    end
    prev_frame = frame_out;
    if (g_frame) begin
      if (g_seen && g_low != 0) chk("gap0_low_run", g_low, 1);
      g_seen = 1;
      g_low = 0;
      if (g_bits.size() == 0) chk("gap0_extra_bit", g_frame, 0);
      else chk("gap0_bit", g_serial, g_bits.pop_front());
    end else g_low++;
    if (gv && g_ready) g_acc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 0; r0v = 1; r1v = 1; r0d = 4'hA; r1d = 4'h5; gv = 0; gd = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_serial", serial_out, 0);
    chk("rst_frame", frame_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready0", r0_ready, 0);
    chk("rst_ready1", r1_ready, 0);
    r0v = 0; r1v = 0;
    @(posedge clk); #1 reset = 1;

    // contention right after reset: req0 first
    gaps.delete();
    r0d = 4'b1100; r1d = 4'b0011;
    push_word(4'b1100, 0); push_word(4'b0011, 1);
    r0v = 1; r1v = 1;
    #1 chk("contend_first_ready0", r0_ready, 1);
    wait_acc(1); r0v = 0;
    wait_acc(1); r1v = 0;
    drain();
    chk_gaps("contend_spacing", 2, 6);

    // single word, then the same requester again at the earliest point
    gaps.delete();
    r0d = 4'b1010; r0v = 1;
    push_word(4'b1010, 0); push_word(4'b0101, 0);
    wait_acc(1); r0d = 4'b0101;
    chk("busy_in_shift", busy, 1);
    chk("ready_in_shift", r0_ready, 0);
    wait_acc(1); r0v = 0;
    drain();
    chk_gaps("single_spacing", 2, 6);

    // only req1 valid
    gaps.delete();
    r1d = 4'b1011; r1v = 1;
    for (int i = 0; i < 3; i++) push_word(4'b1011, 1);
    wait_acc(3); r1v = 0;
    drain();
    chk_gaps("req1_only_spacing", 3, 6);

    // both held: alternate 0,1,0,1
    gaps.delete();
    r0d = 4'b1001; r1d = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      push_word(4'b1001, 0); push_word(4'b0111, 1);
    end
    r0v = 1; r1v = 1;
    wait_acc(4); r0v = 0; r1v = 0;
    drain();
    chk_gaps("alternate_spacing", 4, 6);

    // second requester arrives mid-SHIFT
    gaps.delete();
    r0d = 4'b1010; r0v = 1;
    push_word(4'b1010, 0);
    wait_acc(1); r0v = 0;
    @(posedge clk); #1;
    r1d = 4'b0101; r1v = 1;
    push_word(4'b0101, 1);
    #1;
    for (int k = 0; busy && k < 20; k++) begin
      chk("ready1_while_busy", r1_ready, 0);
      @(posedge clk); #1;
    end
    wait_acc(1); r1v = 0;
    drain();
    chk_gaps("midshift_spacing", 2, 6);

    // reset mid-shift after two bits
    r0d = 4'b1010; r0v = 1;
    push_word(4'b1010, 0);
    wait_acc(1); r0v = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("bits_before_abort", exp_bits.size(), 2);
    reset = 0;
    #1;
    chk("abort_serial", serial_out, 0);
    chk("abort_frame", frame_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_grant", grant_id, 0);
    exp_bits.delete(); exp_gid.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    r1d = 4'b0110; r1v = 1;
    push_word(4'b0110, 1);
    #1 chk("ready1_first_idle", r1_ready, 1);
    wait_acc(1); r1v = 0;
    drain();
    r0d = 4'b1100; r1d = 4'b0011; r0v = 1; r1v = 1;
    push_word(4'b1100, 0); push_word(4'b0011, 1);
    #1;
    chk("post_rst_rr_ready0", r0_ready, 1);
    chk("post_rst_rr_ready1", r1_ready, 0);
    wait_acc(1); r0v = 0;
    wait_acc(1); r1v = 0;
    drain();

    // zero-gap build: back to back words
    gd = 4'b1001; gv = 1;
    for (int i = 0; i < 3; i++)
      for (int j = 3; j >= 0; j--) g_bits.push_back(gd[j]);
    for (int k = 0; g_acc < 3 && k < 100; k++) begin
      @(posedge clk); #1;
    end
    gv = 0;
    chk("gap0_accepts", g_acc, 3);
    for (int k = 0; g_bits.size() > 0 && k < 100; k++) begin
      @(posedge clk); #1;
    end
    chk("gap0_drain", g_bits.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
